// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the adder-sharing arbiter.
// State encoding plus a constant clog2 for sizing requester IDs.
package adder_share_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr,
// wrapping from NUM_REQ-1 back to 0.
import adder_share_pkg::*;

module rr_pick #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    win,
    output logic               any
);

    always_comb begin
        int idx;
        idx = 0;
        win = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any = 1'b1;
                win = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sequencer sharing one external adder among NUM_REQ
// requesters; grant -> one BUSY cycle -> registered result with done pulse.
import adder_share_pkg::*;

module adder_share_arb #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH-1:0]         add_sum
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   win_q;
    logic [ID_W-1:0]   win;
    logic              any;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == ID_W'(i)) begin
                sel_a = op_a[i*WIDTH +: WIDTH];
                sel_b = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            win_q   <= '0;
            grant   <= '0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
            add_a   <= '0;
            add_b   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (any) begin
                        grant <= ONE << win;
                        add_a <= sel_a;
                        add_b <= sel_b;
                        win_q <= win;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    result  <= add_sum;
                    done    <= 1'b1;
                    done_id <= win_q;
                    grant   <= '0;
                    ptr     <= (win_q == LAST_ID) ? '0 : win_q + 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    // No arbitration here so a requester dropping req
                    // on this edge is never served twice.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
